// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter sharing one async SRAM between a write and a read port
// Fixed-length access sequence; every output, including the DQ drive enable, comes from a flop.
module sram_arbiter #(
  parameter int WAIT_CYC = 2,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic              last_wr_q, last_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ce_n_q, ce_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic              busy_q, busy_d;
  logic              grant_wr, grant_rd;

  // On a tie the port that was not served last wins.
  assign grant_wr = i_wr_req && (!i_rd_req || !last_wr_q);
  assign grant_rd = i_rd_req && !grant_wr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    last_wr_d = last_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    ce_n_d    = 1'b1;
    we_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    dq_oe_d   = 1'b0;
    wr_ack_d  = 1'b0;
    rd_ack_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_wr || grant_rd) begin
          state_d   = S_ACCESS;
          cnt_d     = 4'd1;
          op_wr_d   = grant_wr;
          last_wr_d = grant_wr;
          addr_d    = grant_wr ? i_wr_addr : i_rd_addr;
          wdata_d   = grant_wr ? i_wr_data : wdata_q;
          ce_n_d    = 1'b0;
          oe_n_d    = grant_wr;
          dq_oe_d   = grant_wr;
        end
      end
      S_ACCESS: begin
        ce_n_d  = 1'b0;
        dq_oe_d = op_wr_q;
        if (cnt_q == 4'(WAIT_CYC)) begin
          state_d  = S_ACK;
          wr_ack_d = op_wr_q;
          rd_ack_d = !op_wr_q;
          if (!op_wr_q) rd_data_d = io_SRAM_DQ;
        end else begin
          // WE_N falls only after the first cycle so the address has settled.
          cnt_d  = cnt_q + 4'd1;
          we_n_d = !op_wr_q;
          oe_n_d = op_wr_q;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      op_wr_q   <= 1'b0;
      last_wr_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      ce_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_wr_q   <= op_wr_d;
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      ce_n_q    <= ce_n_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      dq_oe_q   <= dq_oe_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign io_SRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;
  assign o_wr_ack    = wr_ack_q;
  assign o_rd_ack    = rd_ack_q;
  assign o_rd_data   = rd_data_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed bench for sram_arbiter with a small SRAM model
// A probe pattern is driven onto DQ to show the arbiter has released the bus.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, rd_req;
  logic [19:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        wr_ack, rd_ack, busy;
  logic [15:0] rd_data;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        we_n, ce_n, oe_n, lb_n, ub_n;

  logic [15:0] mem [16];
  logic        probe_en;
  logic        drv_en;
  logic [15:0] drv_val;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYC(2), .ADDR_W(20), .DATA_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack), .o_rd_data(rd_data),
    .o_busy(busy), .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
    .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
    .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  assign drv_en  = probe_en || (!ce_n && !oe_n && we_n);
  assign drv_val = probe_en ? 16'h5A5A : mem[sram_addr[3:0]];
  assign sram_dq = drv_en ? drv_val : 16'hzzzz;

  always @(posedge we_n) begin
    if (!ce_n) mem[sram_addr[3:0]] <= sram_dq;
  end

  task automatic test_reset;
    rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 20'h00003; wr_data = 16'hC0DE; rd_addr = 20'h00004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (wr_ack !== 1'b0 || rd_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got wr=%b rd=%b want 0 0", wr_ack, rd_ack); end
    end
    n_cmp++; if (sram_addr !== 20'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 00000", sram_addr); end
    n_cmp++; if ({we_n, ce_n, oe_n, lb_n, ub_n} !== 5'b11100) begin n_bad++; $display("FAIL reset_strobes: got %b want 11100", {we_n, ce_n, oe_n, lb_n, ub_n}); end
    n_cmp++; if (busy !== 1'b0 || rd_data !== 16'h0) begin n_bad++; $display("FAIL reset_busy_data: got busy=%b data=%h want 0 0000", busy, rd_data); end
    probe_en = 1'b1; #1;
    n_cmp++; if (sram_dq !== 16'h5A5A) begin n_bad++; $display("FAIL reset_dq_z: got %h want 5a5a (released)", sram_dq); end
    probe_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_tie;
    int     n_ack;
    logic   kind [4];
    int     when [4];
    n_ack = 0;
    for (int c = 1; c <= 24 && n_ack < 4; c++) begin
      @(negedge clk);
      if (wr_ack && rd_ack) begin n_cmp++; n_bad++; $display("FAIL tie_dual_ack: got both acks at cycle %0d want one", c); end
      if (wr_ack || rd_ack) begin kind[n_ack] = wr_ack; when[n_ack] = c; n_ack++; end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    n_cmp++; if (n_ack != 4) begin n_bad++; $display("FAIL tie_count: got %0d acks want 4", n_ack); end
    for (int k = 0; k < n_ack; k++) begin
      n_cmp++; if (kind[k] !== ((k % 2) == 0)) begin n_bad++; $display("FAIL tie_order[%0d]: got wr=%b want %b", k, kind[k], (k % 2) == 0); end
      n_cmp++; if (when[k] != 3 + 4 * k) begin n_bad++; $display("FAIL tie_timing[%0d]: got cycle %0d want %0d", k, when[k], 3 + 4 * k); end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || ce_n !== 1'b1) begin n_bad++; $display("FAIL tie_idle: got busy=%b ce_n=%b want 0 1", busy, ce_n); end
  endtask

  task automatic test_single_write;
    wr_addr = 20'h00005; wr_data = 16'h1234; wr_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (sram_addr !== 20'h00005 || ce_n !== 1'b0 || we_n !== 1'b1 || oe_n !== 1'b1) begin n_bad++; $display("FAIL wr_cyc1: got addr=%h ce=%b we=%b oe=%b want 00005 0 1 1", sram_addr, ce_n, we_n, oe_n); end
    n_cmp++; if (sram_dq !== 16'h1234 || busy !== 1'b1) begin n_bad++; $display("FAIL wr_cyc1_dq: got dq=%h busy=%b want 1234 1", sram_dq, busy); end
    @(negedge clk);
    n_cmp++; if (we_n !== 1'b0 || sram_dq !== 16'h1234 || wr_ack !== 1'b0) begin n_bad++; $display("FAIL wr_cyc2: got we=%b dq=%h ack=%b want 0 1234 0", we_n, sram_dq, wr_ack); end
    @(negedge clk);
    n_cmp++; if (wr_ack !== 1'b1 || we_n !== 1'b1 || ce_n !== 1'b0 || sram_dq !== 16'h1234) begin n_bad++; $display("FAIL wr_ack: got ack=%b we=%b ce=%b dq=%h want 1 1 0 1234", wr_ack, we_n, ce_n, sram_dq); end
    wr_req = 1'b0;
    @(negedge clk);
    probe_en = 1'b1; #1;
    n_cmp++; if (wr_ack !== 1'b0 || ce_n !== 1'b1 || sram_dq !== 16'h5A5A) begin n_bad++; $display("FAIL wr_turnaround: got ack=%b ce=%b dq=%h want 0 1 5a5a", wr_ack, ce_n, sram_dq); end
    probe_en = 1'b0;
    n_cmp++; if (mem[5] !== 16'h1234) begin n_bad++; $display("FAIL wr_mem: got %h want 1234", mem[5]); end
  endtask

  task automatic test_single_read;
    rd_addr = 20'hFFFFF; rd_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (sram_addr !== 20'hFFFFF || oe_n !== 1'b0 || ce_n !== 1'b0 || we_n !== 1'b1) begin n_bad++; $display("FAIL rd_cyc1: got addr=%h oe=%b ce=%b we=%b want fffff 0 0 1", sram_addr, oe_n, ce_n, we_n); end
    @(negedge clk);
    n_cmp++; if (oe_n !== 1'b0 || rd_ack !== 1'b0) begin n_bad++; $display("FAIL rd_cyc2: got oe=%b ack=%b want 0 0", oe_n, rd_ack); end
    @(negedge clk);
    n_cmp++; if (rd_ack !== 1'b1 || rd_data !== 16'hABCD || oe_n !== 1'b1) begin n_bad++; $display("FAIL rd_ack: got ack=%b data=%h oe=%b want 1 abcd 1", rd_ack, rd_data, oe_n); end
    rd_req = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_ack !== 1'b0 || rd_data !== 16'hABCD) begin n_bad++; $display("FAIL rd_hold: got ack=%b data=%h want 0 abcd", rd_ack, rd_data); end
  endtask

  task automatic test_withdraw;
    int acks;
    int first;
    acks = 0; first = 0;
    rd_addr = 20'h00002; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (rd_ack) begin acks++; if (first == 0) first = c; end
    end
    n_cmp++; if (acks != 1 || first != 3) begin n_bad++; $display("FAIL withdraw_ack: got %0d acks first at %0d want 1 at 3", acks, first); end
    n_cmp++; if (rd_data !== 16'h0BEE || busy !== 1'b0) begin n_bad++; $display("FAIL withdraw_data: got data=%h busy=%b want 0bee 0", rd_data, busy); end
  endtask

  task automatic test_reset_mid_write;
    wr_addr = 20'h00007; wr_data = 16'h5555; wr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (we_n !== 1'b0) begin n_bad++; $display("FAIL midrst_pre: got we=%b want 0", we_n); end
    rst = 1'b1;
    @(negedge clk);
    probe_en = 1'b1; #1;
    n_cmp++; if (we_n !== 1'b1 || ce_n !== 1'b1 || sram_dq !== 16'h5A5A) begin n_bad++; $display("FAIL midrst_bus: got we=%b ce=%b dq=%h want 1 1 5a5a", we_n, ce_n, sram_dq); end
    probe_en = 1'b0;
    n_cmp++; if (wr_ack !== 1'b0 || busy !== 1'b0 || rd_data !== 16'h0) begin n_bad++; $display("FAIL midrst_state: got ack=%b busy=%b data=%h want 0 0 0000", wr_ack, busy, rd_data); end
    rst = 1'b0; wr_addr = 20'h00008; wr_data = 16'h6666;
    @(negedge clk);
    n_cmp++; if (sram_addr !== 20'h00008 || sram_dq !== 16'h6666 || wr_ack !== 1'b0) begin n_bad++; $display("FAIL midrst_new_cyc1: got addr=%h dq=%h ack=%b want 00008 6666 0", sram_addr, sram_dq, wr_ack); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL midrst_new_ack: got %b want 1", wr_ack); end
    wr_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem[8] !== 16'h6666 || wr_ack !== 1'b0) begin n_bad++; $display("FAIL midrst_new_mem: got mem=%h ack=%b want 6666 0", mem[8], wr_ack); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[2]  = 16'h0BEE;
    mem[15] = 16'hABCD;
    probe_en = 1'b0;
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    test_reset;
    test_tie;
    test_single_write;
    test_single_read;
    test_withdraw;
    test_reset_mid_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 1M x 16 off-chip SRAM between two requesters: the audio recorder (write port) and the audio player (read port).
- Owns every SRAM pin; Top instantiates it between the recorder/player cores and the o_SRAM_*/io_SRAM_DQ pads.
- Runs a fixed-length access sequence on the asynchronous SRAM and acknowledges each request with a one-cycle pulse.
- Round-robin arbitration prevents either requester from starving the other.

Parameters:
- WAIT_CYC, 2, number of ACCESS cycles per transaction; legal range 2..15.
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.

Ports:
- i_clk  input  1  system clock (12 MHz).
- i_rst  input  1  synchronous reset, active-high.
- i_wr_req  input  1  recorder write request; held high until o_wr_ack.
- i_wr_addr  input  ADDR_W  write address; stable while i_wr_req is high.
- i_wr_data  input  DATA_W  write data; stable while i_wr_req is high.
- o_wr_ack  output  1  one-cycle pulse: write completed.
- i_rd_req  input  1  player read request; held high until o_rd_ack.
- i_rd_addr  input  ADDR_W  read address; stable while i_rd_req is high.
- o_rd_ack  output  1  one-cycle pulse: o_rd_data is valid.
- o_rd_data  output  DATA_W  last read word; held until the next read ack.
- o_busy  output  1  high in every state except IDLE.
- o_SRAM_ADDR  output  ADDR_W  SRAM address.
- io_SRAM_DQ  inout  DATA_W  SRAM data; driven only during write ACCESS/ACK, otherwise Z.
- o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N  output  1 each  SRAM strobes, active-low.
- o_SRAM_LB_N, o_SRAM_UB_N  output  1 each  byte enables; always 0 (word access only).

Behaviour:
- All outputs are registered.
- Reset values: ADDR=0, WE_N=1, CE_N=1, OE_N=1, LB_N=0, UB_N=0, DQ=Z, o_wr_ack=0, o_rd_ack=0, o_rd_data=0, o_busy=0, FSM=IDLE, last_grant=READ.
- FSM has three states: IDLE, ACCESS, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the port that is not last_grant. Write therefore wins the first tie after reset.
  - On grant, latch op, address and write data; update last_grant; go to ACCESS with cycle counter = 1.
- ACCESS (WAIT_CYC cycles):
  - CE_N=0 and ADDR=latched address throughout.
  - Write: DQ driven with the latched data every cycle; WE_N=1 in ACCESS cycle 1 (address setup), WE_N=0 in cycles 2..WAIT_CYC; OE_N=1.
  - Read: OE_N=0 and WE_N=1 every cycle; DQ=Z.
  - On the edge ending the last ACCESS cycle: for a read, capture io_SRAM_DQ into o_rd_data; go to ACK.
- ACK (1 cycle):
  - Pulse the matching ack for exactly one cycle.
  - WE_N=1, OE_N=1, CE_N=0.
  - Write data still driven (hold time); ADDR unchanged.
  - Next state is IDLE, where DQ goes to Z and CE_N to 1. The IDLE cycle is the bus turnaround.
- Latency: request sampled in IDLE at edge E0 → ack visible in the cycle after edge E(WAIT_CYC).
- Throughput: one transaction per WAIT_CYC+2 cycles.
- Inputs are sampled only in IDLE. Changes to a request or its address/data after grant are ignored.
- A transaction, once granted, always completes and acks, even if its request drops mid-access; the requester must ignore an unwanted ack.
- A request still high in the IDLE after its ack is treated as a new request.
- With both ports requesting continuously, grants strictly alternate W, R, W, R...
- Address 20'hFFFFF passes through unchanged; the arbiter performs no address arithmetic.
- Reset asserted mid-transaction: all outputs return to reset values on the next edge; no ack is issued for the aborted access.
- o_rd_data changes only at read capture or reset.

Test Plan:
- Reset: hold i_rst=1 for 3 cycles with both requests high → reset values above, no ack, o_busy=0, DQ=Z.
- Single write, WAIT_CYC=2: wr_addr=20'h00005, wr_data=16'h1234 →
  - cycle 1: ADDR=5, CE_N=0, WE_N=1, DQ=1234.
  - cycle 2: WE_N=0.
  - cycle 3: o_wr_ack=1 for one cycle.
  - cycle 4: DQ=Z, CE_N=1.
- Single read: SRAM model holds 16'hABCD at 20'hFFFFF; rd_addr=20'hFFFFF → OE_N=0 for 2 cycles; o_rd_ack pulse with o_rd_data=16'hABCD, held afterwards.
- Tie, both requests held for 4 transactions → grant order W, R, W, R. Each ack is separated from the next by 4 cycles. The write-first order also holds directly after reset.
- Request withdrawn: drop i_rd_req in ACCESS cycle 1 → read still completes, o_rd_ack pulses once, no further read starts.
- Reset mid-write: assert i_rst in ACCESS cycle 2 → next edge WE_N=1, CE_N=1, DQ=Z; no o_wr_ack; a fresh write after reset completes normally.
